// File: rtl/relu_layer_sequencer.sv
// Streams one feature map out of the activation buffer through a signed ReLU.
// Reads are credit-limited so that the 2-entry output FIFO can never overflow.
`timescale 1ns / 1ps
module relu_layer_sequencer #(
  parameter int unsigned DATAW = 8,
  parameter int unsigned DIMW  = 9,
  parameter int unsigned CHW   = 10,
  parameter int unsigned ADDRW = 20
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             abort,
  input  logic [DIMW-1:0]  cfg_w,
  input  logic [DIMW-1:0]  cfg_h,
  input  logic [CHW-1:0]   cfg_c,
  input  logic [ADDRW-1:0] cfg_base,
  output logic             rd_en,
  output logic [ADDRW-1:0] rd_addr,
  input  logic [DATAW-1:0] rd_data,
  output logic             out_valid,
  output logic [DATAW-1:0] out_data,
  output logic             out_last,
  input  logic             out_ready,
  output logic             busy,
  output logic             done
);

  localparam int unsigned TOTW = 2 * DIMW + CHW;

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e           state;
  logic [TOTW-1:0]  total;
  logic [TOTW-1:0]  issued;
  logic [TOTW-1:0]  cfg_total;
  logic [ADDRW-1:0] base;
  logic             pend;
  logic             pend_last;
  logic [DATAW:0]   fifo_mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;
  logic [1:0]       count_nxt;
  logic [2:0]       occ;
  logic             pop;
  logic             last_rd;
  logic [DATAW-1:0] relu_data;

  // occ counts FIFO entries plus the read whose data arrives this cycle, net of
  // this cycle's pop, so a read and a pop in the same cycle keep 1 element/clk.
  always_comb begin
    cfg_total = TOTW'(cfg_w) * TOTW'(cfg_h) * TOTW'(cfg_c);
    pop       = (count != 2'd0) && out_ready;
    occ       = 3'(count) + 3'(pend) - 3'(pop);
    rd_en     = (state == StRun) && !abort && (occ < 3'd2);
    last_rd   = (issued == total - TOTW'(1));
    count_nxt = count + 2'(pend) - 2'(pop);
    relu_data = rd_data[DATAW-1] ? '0 : rd_data;
  end

  assign rd_addr   = base + ADDRW'(issued);
  assign out_valid = (count != 2'd0);
  assign out_data  = fifo_mem[rd_ptr][DATAW-1:0];
  assign out_last  = fifo_mem[rd_ptr][DATAW];
  assign busy      = (state != StIdle);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= StIdle;
      total       <= '0;
      issued      <= '0;
      base        <= '0;
      pend        <= 1'b0;
      pend_last   <= 1'b0;
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      count       <= '0;
      done        <= 1'b0;
    end else if (abort) begin
      // In-flight read data is dropped by clearing pend.
      state     <= StIdle;
      pend      <= 1'b0;
      pend_last <= 1'b0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      count     <= '0;
      done      <= 1'b0;
    end else begin
      done      <= 1'b0;
      pend      <= rd_en;
      pend_last <= rd_en && last_rd;
      count     <= count_nxt;
      if (pend) begin
        fifo_mem[wr_ptr] <= {pend_last, relu_data};
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      if (rd_en) issued <= issued + TOTW'(1);
      unique case (state)
        StIdle: begin
          if (start) begin
            total  <= cfg_total;
            base   <= cfg_base;
            issued <= '0;
            state  <= (cfg_total == '0) ? StDone : StRun;
          end
        end
        StRun: begin
          if (rd_en && last_rd) state <= StDrain;
        end
        StDrain: begin
          if (occ == 3'd0) state <= StDone;
        end
        StDone: begin
          done  <= 1'b1;
          state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_relu_layer_sequencer.sv
// Scoreboard bench for relu_layer_sequencer: a buffer model feeds reads, the map's
// expected ReLU stream is queued at start and a negedge monitor checks every handshake.
`timescale 1ns / 1ps
module tb_relu_layer_sequencer;
  localparam int unsigned DATAW = 8;
  localparam int unsigned DIMW  = 9;
  localparam int unsigned CHW   = 10;
  localparam int unsigned ADDRW = 20;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [DIMW-1:0]  cfg_w = '0;
  logic [DIMW-1:0]  cfg_h = '0;
  logic [CHW-1:0]   cfg_c = '0;
  logic [ADDRW-1:0] cfg_base = '0;
  logic             rd_en;
  logic [ADDRW-1:0] rd_addr;
  logic [DATAW-1:0] rd_data = '0;
  logic             out_valid;
  logic [DATAW-1:0] out_data;
  logic             out_last;
  logic             out_ready = 1'b0;
  logic             busy;
  logic             done;

  relu_layer_sequencer #(.DATAW(DATAW), .DIMW(DIMW), .CHW(CHW), .ADDRW(ADDRW)) dut (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort),
    .cfg_w(cfg_w), .cfg_h(cfg_h), .cfg_c(cfg_c), .cfg_base(cfg_base),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } elem_t;

  elem_t            exp_q[$];
  logic [7:0]       bufmem [4096];
  int               n_cmp = 0;
  int               n_fail = 0;
  int               cyc = 0;
  int               n_rd = 0;
  int               n_acc = 0;
  int               n_done = 0;
  int               n_vcyc = 0;
  int               lost = 0;
  int               map_rd0 = 0;
  int               acc_cyc = 0;
  int               last_rd_cyc = 0;
  int               last_acc_cyc = 0;
  int               done_cyc = 0;
  int               ready_mode = 0;
  logic [ADDRW-1:0] exp_base = '0;
  logic             stalled_prev = 1'b0;
  logic             abort_prev = 1'b0;
  elem_t            held;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Activation buffer: data one cycle after the read strobe, junk otherwise.
  always @(posedge clk) rd_data <= rd_en ? bufmem[rd_addr[11:0]] : 8'($urandom);

  always @(posedge clk) begin
    #2;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      2:       out_ready = (cyc % 3 == 0);
      default: out_ready = 1'b0;
    endcase
  end

  always @(negedge clk) begin
    elem_t e;
    if (!rstn) begin
      exp_q.delete();
      lost         = n_rd - n_acc;
      stalled_prev = 1'b0;
    end else begin
      if (stalled_prev && !abort_prev)
        check("hold", {out_valid, out_last, out_data}, {1'b1, held});
      if (out_valid) n_vcyc++;
      if (out_valid && out_ready) begin
        n_acc++;
        last_acc_cyc = cyc;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL extra_output: got data %0d last %0d, expected no output",
                   out_data, out_last);
        end else begin
          e = exp_q.pop_front();
          check("out_data", out_data, e.data);
          check("out_last", out_last, e.last);
        end
      end
      if (rd_en) begin
        check("rd_addr", rd_addr, exp_base + ADDRW'(n_rd - map_rd0));
        n_rd++;
        last_rd_cyc = cyc;
        check("credit", (n_rd - n_acc - lost) <= 2, 1);
      end
      if (done) begin
        n_done++;
        done_cyc = cyc;
      end
      stalled_prev = out_valid && !out_ready;
      held         = {out_last, out_data};
      if (abort) begin
        exp_q.delete();
        lost = n_rd - n_acc;
      end
      abort_prev = abort;
    end
  end

  // Drives one accepted start; the reference stream is every element in linear
  // order with negatives clamped to zero and the final element flagged last.
  task automatic start_map(input int w, input int h, input int c, input logic [ADDRW-1:0] base,
                           input bit model);
    int               total;
    logic [ADDRW-1:0] a;
    logic signed [7:0] v;
    elem_t            e;
    total = w * h * c;
    @(posedge clk);
    #1;
    cfg_w    = DIMW'(w);
    cfg_h    = DIMW'(h);
    cfg_c    = CHW'(c);
    cfg_base = base;
    start    = 1'b1;
    exp_base = base;
    map_rd0  = n_rd;
    if (model) begin
      for (int i = 0; i < total; i++) begin
        a      = base + ADDRW'(i);
        v      = bufmem[a[11:0]];
        e.last = (i == total - 1);
        e.data = (v < 0) ? 8'd0 : v;
        exp_q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    start   = 1'b0;
    acc_cyc = cyc;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n0;
    int k;
    n0 = n_done;
    k  = 0;
    while (n_done == n0 && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    check({name, "_done"}, n_done - n0, 1);
    @(negedge clk);
    #1;
    check({name, "_drained"}, exp_q.size(), 0);
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_rd_en"}, rd_en, 0);
    check({name, "_rd_addr"}, rd_addr, 0);
    check({name, "_out_valid"}, out_valid, 0);
    check({name, "_out_data"}, out_data, 0);
    check({name, "_out_last"}, out_last, 0);
    check({name, "_busy"}, busy, 0);
    check({name, "_done"}, done, 0);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int a0;
    int d0;
    int r0;
    int v0;
    elem_t e;
    for (int i = 0; i < 4096; i++) bufmem[i] = 8'($urandom);

    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rstn = 1'b1;

    // Directed 2x2x1: {-3, 5, 0, -128} -> {0, 5, 0, 0}
    ready_mode = 0;
    bufmem[12'h100] = 8'hfd;
    bufmem[12'h101] = 8'h05;
    bufmem[12'h102] = 8'h00;
    bufmem[12'h103] = 8'h80;
    e = '{last: 1'b0, data: 8'd0}; exp_q.push_back(e);
    e = '{last: 1'b0, data: 8'd5}; exp_q.push_back(e);
    e = '{last: 1'b0, data: 8'd0}; exp_q.push_back(e);
    e = '{last: 1'b1, data: 8'd0}; exp_q.push_back(e);
    start_map(2, 2, 1, 20'h00100, 1'b0);
    k = 0;
    @(negedge clk);
    while (!out_valid && k < 10) begin
      @(negedge clk);
      k++;
    end
    check("first_valid_latency", cyc - acc_cyc, 2);
    wait_done("map2x2", 50);
    check("done_after_last_read", done_cyc - last_rd_cyc, 4);
    check("map2x2_reads", n_rd - map_rd0, 4);

    // Full-throughput map
    a0 = n_acc;
    d0 = n_done;
    start_map(20, 16, 3, 20'h0ffc0, 1'b1);
    wait_done("full", 3000);
    check("full_handshakes", n_acc - a0, 960);
    check("full_span", last_acc_cyc - acc_cyc + 1, 962);
    check("full_single_done", n_done - d0, 1);

    // Backpressure pattern 1,0,0
    ready_mode = 2;
    start_map(3, 1, 1, 20'h00a31, 1'b1);
    wait_done("stall3", 100);

    // Empty map
    ready_mode = 0;
    r0 = n_rd;
    v0 = n_vcyc;
    start_map(5, 4, 0, 20'h00200, 1'b1);
    wait_done("empty", 20);
    check("empty_done_cycle", done_cyc - acc_cyc, 1);
    check("empty_no_reads", n_rd - r0, 0);
    check("empty_no_valid", n_vcyc - v0, 0);

    // Abort on the 5th read, then a clean map
    start_map(4, 4, 1, 20'h00300, 1'b1);
    k = 0;
    while ((n_rd - map_rd0) < 5 && k < 100) begin
      @(negedge clk);
      #1;
      k++;
    end
    check("abort_reach5", n_rd - map_rd0, 5);
    @(posedge clk);
    #1;
    ready_mode = 3;
    abort      = 1'b1;
    d0         = n_done;
    @(posedge clk);
    #1;
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_valid", out_valid, 0);
    check("abort_rd_en", rd_en, 0);
    repeat (4) @(negedge clk);
    #1;
    check("abort_no_done", n_done - d0, 0);
    ready_mode = 1;
    start_map(2, 3, 1, 20'h00400, 1'b1);
    wait_done("after_abort", 100);

    // Start re-pulsed while running is ignored
    d0 = n_done;
    start_map(4, 2, 1, 20'h00500, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    cfg_w    = 9'd1;
    cfg_h    = 9'd1;
    cfg_c    = 10'd1;
    cfg_base = 20'h00777;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("restart_ignored", 200);
    repeat (3) @(negedge clk);
    check("restart_single_done", n_done - d0, 1);
    check("restart_reads", n_rd - map_rd0, 8);

    // Randomized maps
    for (int m = 0; m < 8; m++) begin
      ready_mode = $urandom_range(0, 2);
      start_map($urandom_range(1, 6), $urandom_range(1, 4), $urandom_range(0, 3),
                20'($urandom), 1'b1);
      wait_done("rand", 600);
    end

    // Asynchronous reset mid-map
    ready_mode = 1;
    d0 = n_done;
    start_map(8, 8, 1, 20'h00800, 1'b1);
    repeat (10) @(posedge clk);
    #3;
    rstn = 1'b0;
    #1;
    check_idle_outputs("async_reset");
    @(negedge clk);
    @(posedge clk);
    #3;
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_no_done", n_done - d0, 0);
    ready_mode = 0;
    start_map(3, 2, 2, 20'h00900, 1'b1);
    wait_done("after_reset", 100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
